// File: rtl/tl_pkg.sv
// Shared TileLink definitions for the uncached heavyweight arbiter.
//   - A/D opcode encodings used to decide burst lengths
//   - arbiter state enum
//   - tl_beats(): beats in a burst of 2**size bytes on a 32-bit bus, clamped to max_size
package tl_pkg;

    localparam logic [2:0] A_GET        = 3'd4;
    localparam logic [2:0] A_PUTFULL    = 3'd0;
    localparam logic [2:0] A_PUTPARTIAL = 3'd1;
    localparam logic [2:0] D_ACK        = 3'd0;
    localparam logic [2:0] D_ACKDATA    = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Oversized requests are clamped so the counter can never wrap.
    function automatic int unsigned tl_beats(input logic [3:0] size, input int unsigned max_size);
        int unsigned s;
        s = 32'(size);
        if (s > max_size) s = max_size;
        if (s <= 32'd2) return 32'd1;
        return 32'd1 << (s - 32'd2);
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Remaining-beat counter shared by the A and D phases of a transaction.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load count_i (takes priority over dec_i)
//   dec_i        : one beat handshaken
//   last_o       : exactly one beat remains
module tl_beat_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] count_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= count_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign last_o = (r_count == W'(1));

endmodule

// File: rtl/tl_uh_arbiter.sv
// Two-master / one-slave round-robin arbiter for the uncached heavyweight
// TileLink port. One transaction in flight; the grant is held from the first
// A beat to the last D beat so bursts never interleave.
//   core_clock_i, core_reset_i : clock, synchronous active-high reset
//   m0_a_* / m1_a_*            : A channel from the I-cache refill / uncached LSU
//   m0_d_* / m1_d_*            : D channel back to each master (valid gated by grant)
//   s_a_* / s_d_*              : single bus port
//   busy_o                     : transaction in flight
module tl_uh_arbiter
    import tl_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 6,
    parameter bit          M0_FIRST = 1'b1
) (
    input  logic        core_clock_i,
    input  logic        core_reset_i,
    input  logic [2:0]  m0_a_opcode,
    input  logic [2:0]  m0_a_param,
    input  logic [3:0]  m0_a_size,
    input  logic [31:0] m0_a_address,
    input  logic [3:0]  m0_a_mask,
    input  logic [31:0] m0_a_data,
    input  logic        m0_a_corrupt,
    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    output logic [2:0]  m0_d_opcode,
    output logic [1:0]  m0_d_param,
    output logic [3:0]  m0_d_size,
    output logic        m0_d_denied,
    output logic [31:0] m0_d_data,
    output logic        m0_d_corrupt,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,
    input  logic [2:0]  m1_a_opcode,
    input  logic [2:0]  m1_a_param,
    input  logic [3:0]  m1_a_size,
    input  logic [31:0] m1_a_address,
    input  logic [3:0]  m1_a_mask,
    input  logic [31:0] m1_a_data,
    input  logic        m1_a_corrupt,
    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    output logic [2:0]  m1_d_opcode,
    output logic [1:0]  m1_d_param,
    output logic [3:0]  m1_d_size,
    output logic        m1_d_denied,
    output logic [31:0] m1_d_data,
    output logic        m1_d_corrupt,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,
    output logic [2:0]  s_a_opcode,
    output logic [2:0]  s_a_param,
    output logic [3:0]  s_a_size,
    output logic [31:0] s_a_address,
    output logic [3:0]  s_a_mask,
    output logic [31:0] s_a_data,
    output logic        s_a_corrupt,
    output logic        s_a_valid,
    input  logic        s_a_ready,
    input  logic [2:0]  s_d_opcode,
    input  logic [1:0]  s_d_param,
    input  logic [3:0]  s_d_size,
    input  logic        s_d_denied,
    input  logic [31:0] s_d_data,
    input  logic        s_d_corrupt,
    input  logic        s_d_valid,
    output logic        s_d_ready,
    output logic        busy_o
);

    localparam int unsigned CW = MAX_SIZE - 2 + 1;

    state_t        r_state;
    logic          r_gnt;
    logic          r_rr;      // master served last
    logic          r_first;   // next handshake is the first beat of the current phase

    logic          w_hs;
    logic          w_last;
    logic          w_cnt_last;
    logic          w_load;
    logic          w_dec;
    logic [CW-1:0] w_beats;
    logic [CW-1:0] w_a_beats;
    logic [CW-1:0] w_d_beats;
    logic [CW-1:0] w_load_val;

    // Burst length is taken from the fields presented with the first beat;
    // after that only the counter decides.
    assign w_a_beats  = (s_a_opcode == A_PUTFULL || s_a_opcode == A_PUTPARTIAL)
                        ? CW'(tl_beats(s_a_size, MAX_SIZE)) : CW'(1);
    assign w_d_beats  = (s_d_opcode == D_ACKDATA) ? CW'(tl_beats(s_d_size, MAX_SIZE)) : CW'(1);
    assign w_beats    = (r_state == RESP) ? w_d_beats : w_a_beats;
    assign w_hs       = ((r_state == REQ)  && s_a_valid && s_a_ready) ||
                        ((r_state == RESP) && s_d_valid && s_d_ready);
    assign w_last     = r_first ? (w_beats == CW'(1)) : w_cnt_last;
    assign w_load     = w_hs && (r_first || w_last);
    assign w_load_val = w_last ? '0 : (w_beats - CW'(1));
    assign w_dec      = w_hs && !w_load;

    tl_beat_counter #(.W(CW)) u_beat_counter (
        .clk_i   (core_clock_i),
        .rst_i   (core_reset_i),
        .load_i  (w_load),
        .count_i (w_load_val),
        .dec_i   (w_dec),
        .last_o  (w_cnt_last)
    );

    // Arbitration and phase sequencing.
    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_rr    <= M0_FIRST;
            r_first <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_first <= 1'b1;
                    if (m0_a_valid && m1_a_valid) begin
                        r_gnt   <= ~r_rr;
                        r_state <= REQ;
                    end else if (m0_a_valid) begin
                        r_gnt   <= 1'b0;
                        r_state <= REQ;
                    end else if (m1_a_valid) begin
                        r_gnt   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_hs) begin
                        r_first <= w_last;
                        if (w_last) r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_hs) begin
                        r_first <= w_last;
                        if (w_last) begin
                            r_state <= IDLE;
                            r_rr    <= r_gnt;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Routing through the registered grant; no ready-to-valid path on the bus side.
    always_comb begin
        s_a_opcode  = r_gnt ? m1_a_opcode  : m0_a_opcode;
        s_a_param   = r_gnt ? m1_a_param   : m0_a_param;
        s_a_size    = r_gnt ? m1_a_size    : m0_a_size;
        s_a_address = r_gnt ? m1_a_address : m0_a_address;
        s_a_mask    = r_gnt ? m1_a_mask    : m0_a_mask;
        s_a_data    = r_gnt ? m1_a_data    : m0_a_data;
        s_a_corrupt = r_gnt ? m1_a_corrupt : m0_a_corrupt;
        s_a_valid   = (r_state == REQ) && (r_gnt ? m1_a_valid : m0_a_valid);
        m0_a_ready  = (r_state == REQ) && !r_gnt && s_a_ready;
        m1_a_ready  = (r_state == REQ) &&  r_gnt && s_a_ready;
        m0_d_valid  = (r_state == RESP) && !r_gnt && s_d_valid;
        m1_d_valid  = (r_state == RESP) &&  r_gnt && s_d_valid;
        s_d_ready   = (r_state == RESP) && (r_gnt ? m1_d_ready : m0_d_ready);
        busy_o      = (r_state != IDLE);
    end

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_denied  = s_d_denied;
    assign m0_d_data    = s_d_data;
    assign m0_d_corrupt = s_d_corrupt;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_denied  = s_d_denied;
    assign m1_d_data    = s_d_data;
    assign m1_d_corrupt = s_d_corrupt;

endmodule

// File: tb/tb_tl_uh_arbiter.sv
// Scoreboard bench for tl_uh_arbiter: directed transactions push expected A/D
// beats into queues; a negedge monitor pops and compares on every handshake.
module tb_tl_uh_arbiter;
    import tl_pkg::*;

    logic        core_clock_i, core_reset_i;
    logic [2:0]  m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param, s_a_opcode, s_a_param;
    logic [3:0]  m0_a_size, m0_a_mask, m1_a_size, m1_a_mask, s_a_size, s_a_mask;
    logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data, s_a_address, s_a_data;
    logic        m0_a_corrupt, m0_a_valid, m0_a_ready, m1_a_corrupt, m1_a_valid, m1_a_ready;
    logic        s_a_corrupt, s_a_valid, s_a_ready;
    logic [2:0]  m0_d_opcode, m1_d_opcode, s_d_opcode;
    logic [1:0]  m0_d_param, m1_d_param, s_d_param;
    logic [3:0]  m0_d_size, m1_d_size, s_d_size;
    logic        m0_d_denied, m1_d_denied, s_d_denied;
    logic [31:0] m0_d_data, m1_d_data, s_d_data;
    logic        m0_d_corrupt, m1_d_corrupt, s_d_corrupt;
    logic        m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready, s_d_valid, s_d_ready, busy_o;

    tl_uh_arbiter #(.MAX_SIZE(6), .M0_FIRST(1'b1)) dut (
        .core_clock_i(core_clock_i), .core_reset_i(core_reset_i),
        .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
        .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
        .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data), .m0_d_corrupt(m0_d_corrupt),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
        .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
        .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data), .m1_d_corrupt(m1_d_corrupt),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_denied(s_d_denied), .s_d_data(s_d_data), .s_d_corrupt(s_d_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .busy_o(busy_o)
    );

    typedef struct packed {
        logic        m;
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
    } a_exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  sz;
        logic        den;
        logic [31:0] data;
    } d_exp_t;

    a_exp_t exp_a[$];
    d_exp_t exp_d0[$];
    d_exp_t exp_d1[$];
    int     errors = 0;
    int     checks = 0;
    bit     a_tog  = 1'b1;

    initial core_clock_i = 1'b0;
    always #5 core_clock_i = ~core_clock_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every handshake must match the head of its queue.
    always @(negedge core_clock_i) begin
        a_exp_t ea;
        d_exp_t ed;
        if (!core_reset_i) begin
            if (s_a_valid && s_a_ready) begin
                chk("a_beat_expected", 64'(exp_a.size() != 0), 64'd1);
                if (exp_a.size() != 0) begin
                    ea = exp_a.pop_front();
                    chk("a_granted_ready", 64'(ea.m ? m1_a_ready : m0_a_ready), 64'd1);
                    chk("a_other_ready", 64'(ea.m ? m0_a_ready : m1_a_ready), 64'd0);
                    chk("a_opcode", 64'(s_a_opcode), 64'(ea.op));
                    chk("a_size", 64'(s_a_size), 64'(ea.sz));
                    chk("a_address", 64'(s_a_address), 64'(ea.addr));
                    chk("a_data", 64'(s_a_data), 64'(ea.data));
                end
            end
            if (m0_d_valid) chk("d0_valid_expected", 64'(exp_d0.size() != 0), 64'd1);
            if (m1_d_valid) chk("d1_valid_expected", 64'(exp_d1.size() != 0), 64'd1);
            if (m0_d_valid && m0_d_ready && exp_d0.size() != 0) begin
                ed = exp_d0.pop_front();
                chk("d0_opcode", 64'(m0_d_opcode), 64'(ed.op));
                chk("d0_denied", 64'(m0_d_denied), 64'(ed.den));
                chk("d0_data", 64'(m0_d_data), 64'(ed.data));
            end
            if (m1_d_valid && m1_d_ready && exp_d1.size() != 0) begin
                ed = exp_d1.pop_front();
                chk("d1_opcode", 64'(m1_d_opcode), 64'(ed.op));
                chk("d1_denied", 64'(m1_d_denied), 64'(ed.den));
                chk("d1_data", 64'(m1_d_data), 64'(ed.data));
            end
        end
    end

    task automatic tick();
        @(posedge core_clock_i);
        #1;
    endtask

    task automatic drive_a(input bit m, input logic v, input logic [2:0] op, input logic [3:0] sz,
                           input logic [31:0] addr, input logic [31:0] data);
        if (m) begin
            m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_address = addr;
            m1_a_data = data; m1_a_param = 3'd0; m1_a_mask = 4'hF; m1_a_corrupt = 1'b0;
        end else begin
            m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_address = addr;
            m0_a_data = data; m0_a_param = 3'd0; m0_a_mask = 4'hF; m0_a_corrupt = 1'b0;
        end
    endtask

    task automatic push_a(input bit m, input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] addr, input logic [31:0] data);
        a_exp_t e;
        e = '{m: m, op: op, sz: sz, addr: addr, data: data};
        exp_a.push_back(e);
    endtask

    // Waits for master m's A handshake; n = cycles with no handshake first.
    task automatic wait_a(input bit m, input bit toggle, output int n);
        bit hs;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 40) begin
            if (toggle) begin
                s_a_ready = a_tog;
                a_tog     = ~a_tog;
            end
            @(negedge core_clock_i);
            hs = m ? m1_a_ready : m0_a_ready;
            tick();
            if (!hs) n++;
        end
        chk("a_handshake_seen", 64'(hs), 64'd1);
    endtask

    task automatic a_burst(input bit m, input logic [2:0] op, input logic [3:0] sz,
                           input logic [31:0] addr, input int nbeats, input bit toggle,
                           output int first_lat);
        int n;
        first_lat = 0;
        a_tog     = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            drive_a(m, 1'b1, op, sz, addr + 32'(4 * i), {addr[15:0], 16'(i)});
            push_a(m, op, sz, addr + 32'(4 * i), {addr[15:0], 16'(i)});
            wait_a(m, toggle, n);
            if (i == 0) first_lat = n;
        end
        if (m) m1_a_valid = 1'b0; else m0_a_valid = 1'b0;
        s_a_ready = 1'b1;
    endtask

    task automatic set_dready(input bit m, input logic v);
        if (m) m1_d_ready = v; else m0_d_ready = v;
    endtask

    // Bus-side D burst; optional stall window and reset abort at a given beat index.
    task automatic d_burst(input bit m, input logic [2:0] op, input logic [3:0] sz, input logic den,
                           input int nbeats, input int stall_beat, input int stall_len,
                           input int abort_beat);
        d_exp_t e;
        bit     hs;
        int     n;
        for (int i = 0; i < nbeats; i++) begin
            s_d_opcode = op; s_d_size = sz; s_d_denied = den; s_d_param = 2'd0;
            s_d_corrupt = 1'b0; s_d_data = 32'hD000_0000 | (32'(m) << 20) | 32'(i);
            s_d_valid = 1'b1;
            if (i == abort_beat) begin
                core_reset_i = 1'b1;
                s_a_ready = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
                tick();
                core_reset_i = 1'b0;
                @(negedge core_clock_i);
                chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
                chk("rst_m0_a_ready", 64'(m0_a_ready), 64'd0);
                chk("rst_m1_a_ready", 64'(m1_a_ready), 64'd0);
                chk("rst_m0_d_valid", 64'(m0_d_valid), 64'd0);
                chk("rst_m1_d_valid", 64'(m1_d_valid), 64'd0);
                chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
                chk("rst_busy", 64'(busy_o), 64'd0);
                tick();
                s_d_valid = 1'b0;
                return;
            end
            e = '{op: op, sz: sz, den: den, data: s_d_data};
            if (m) exp_d1.push_back(e); else exp_d0.push_back(e);
            if (i == stall_beat) begin
                for (int k = 0; k < stall_len; k++) begin
                    set_dready(m, 1'b0);
                    @(negedge core_clock_i);
                    chk("stall_s_d_ready", 64'(s_d_ready), 64'd0);
                    tick();
                end
            end
            set_dready(m, 1'b1);
            n  = 0;
            hs = 1'b0;
            while (!hs && n < 40) begin
                @(negedge core_clock_i);
                hs = s_d_ready;
                if (hs) chk("busy_during_d", 64'(busy_o), 64'd1);
                tick();
                n++;
            end
            chk("d_handshake_seen", 64'(hs), 64'd1);
            if (!hs) begin
                s_d_valid = 1'b0;
                return;
            end
        end
        s_d_valid = 1'b0;
    endtask

    task automatic expect_idle(input string nm);
        @(negedge core_clock_i);
        chk(nm, 64'(busy_o), 64'd0);
        tick();
    endtask

    // Both masters request in the same IDLE cycle; 'first' must win, the other
    // gets granted the cycle after the winner's last D beat.
    task automatic pair_round(input bit first);
        int n;
        drive_a(1'b0, 1'b1, A_GET, 4'd2, 32'h2000_0000, 32'h0000_00A0);
        drive_a(1'b1, 1'b1, A_GET, 4'd2, 32'h3000_0000, 32'h0000_00A1);
        push_a(first, A_GET, 4'd2, first ? 32'h3000_0000 : 32'h2000_0000,
               first ? 32'h0000_00A1 : 32'h0000_00A0);
        push_a(~first, A_GET, 4'd2, first ? 32'h2000_0000 : 32'h3000_0000,
               first ? 32'h0000_00A0 : 32'h0000_00A1);
        wait_a(first, 1'b0, n);
        chk("pair_first_latency", 64'(n), 64'd1);
        if (first) m1_a_valid = 1'b0; else m0_a_valid = 1'b0;
        d_burst(first, D_ACKDATA, 4'd2, 1'b0, 1, -1, 0, -1);
        @(negedge core_clock_i);
        chk("pair_gap_busy", 64'(busy_o), 64'd0);
        chk("pair_gap_s_a_valid", 64'(s_a_valid), 64'd0);
        tick();
        wait_a(~first, 1'b0, n);
        chk("pair_second_latency", 64'(n), 64'd0);
        if (first) m0_a_valid = 1'b0; else m1_a_valid = 1'b0;
        d_burst(~first, D_ACKDATA, 4'd2, 1'b0, 1, -1, 0, -1);
        expect_idle("pair_end_busy");
    endtask

    initial begin
        int lat;
        core_reset_i = 1'b1;
        drive_a(1'b0, 1'b1, A_GET, 4'd2, 32'h0, 32'h0);
        drive_a(1'b1, 1'b1, A_GET, 4'd2, 32'h0, 32'h0);
        s_a_ready = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        s_d_opcode = D_ACK; s_d_param = 2'd0; s_d_size = 4'd0; s_d_denied = 1'b0;
        s_d_data = 32'h0; s_d_corrupt = 1'b0; s_d_valid = 1'b1;
        tick();
        tick();
        @(negedge core_clock_i);
        chk("reset_s_a_valid", 64'(s_a_valid), 64'd0);
        chk("reset_a_ready", 64'({m0_a_ready, m1_a_ready}), 64'd0);
        chk("reset_d_valid", 64'({m0_d_valid, m1_d_valid}), 64'd0);
        chk("reset_s_d_ready", 64'(s_d_ready), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        tick();
        core_reset_i = 1'b0; m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_d_valid = 1'b0;
        tick();

        // Alternation from reset: m0, m1, then m0 again.
        pair_round(1'b0);
        pair_round(1'b0);

        // m0 Get of 64 bytes: 1 A beat, 16 D beats, only on m0.
        a_burst(1'b0, A_GET, 4'd6, 32'h1000_0040, 1, 1'b0, lat);
        chk("get_a_latency", 64'(lat), 64'd1);
        d_burst(1'b0, D_ACKDATA, 4'd6, 1'b0, 16, -1, 0, -1);
        expect_idle("get_end_busy");

        // m0 was served last, so a simultaneous pair now favours m1.
        pair_round(1'b1);

        // m1 PutFullData 16 bytes with a toggling bus ready: 4 A beats, one AccessAck.
        a_burst(1'b1, A_PUTFULL, 4'd4, 32'h4000_0100, 4, 1'b1, lat);
        d_burst(1'b1, D_ACK, 4'd4, 1'b0, 1, -1, 0, -1);
        expect_idle("putfull_end_busy");

        // PutPartialData at size 2 is a single beat.
        a_burst(1'b0, A_PUTPARTIAL, 4'd2, 32'h4000_0200, 1, 1'b0, lat);
        d_burst(1'b0, D_ACK, 4'd0, 1'b0, 1, -1, 0, -1);
        expect_idle("putpartial_end_busy");

        // Denied AccessAckData still runs the full 16 beats.
        a_burst(1'b1, A_GET, 4'd6, 32'h5000_0000, 1, 1'b0, lat);
        d_burst(1'b1, D_ACKDATA, 4'd6, 1'b1, 16, -1, 0, -1);
        expect_idle("denied_end_busy");

        // D backpressure from m0 for 3 cycles mid-burst.
        a_burst(1'b0, A_GET, 4'd6, 32'h6000_0000, 1, 1'b0, lat);
        d_burst(1'b0, D_ACKDATA, 4'd6, 1'b0, 16, 7, 3, -1);
        expect_idle("stall_end_busy");

        // Reset during beat 5 of a 16-beat burst; m0 was last served, yet the
        // restored pointer must favour m0 in the following pair.
        a_burst(1'b0, A_GET, 4'd6, 32'h7000_0000, 1, 1'b0, lat);
        d_burst(1'b0, D_ACKDATA, 4'd6, 1'b0, 16, -1, 0, 4);
        pair_round(1'b0);

        chk("exp_a_drained", 64'(exp_a.size()), 64'd0);
        chk("exp_d0_drained", 64'(exp_d0.size()), 64'd0);
        chk("exp_d1_drained", 64'(exp_d1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
